cache_mem_arbiter: RTL and testbench

//  Shares one physical-memory line port between the pipeline's I-cache (read-only) and D-cache (read/write).

---
 rtl/cache_mem_arbiter_pkg.sv | 19 +
 rtl/cache_mem_arbiter_priority_select.sv | 41 ++++
 rtl/cache_mem_arbiter.sv | 142 ++++++++++++++
 tb/tb_cache_mem_arbiter.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// rv32i_types: shared arbiter types.
//   arb_state_t : arbiter FSM states (IDLE, I_BUSY, D_BUSY, DONE)
//   arb_grant_t : which cache owns the memory port (GRANT_I, GRANT_D)
// Configuration macro used by the arbiter files: ARB_ROUND_ROBIN_EN.
package rv32i_types;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        I_BUSY = 2'd1,
        D_BUSY = 2'd2,
        DONE   = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } arb_grant_t;

endpackage

// File: rtl/cache_mem_arbiter_priority_select.sv
// arb_priority_select: combinational winner pick between I-cache and D-cache.
// Ports:
//   icache_read  in  I-cache request
//   dcache_req   in  D-cache request (read or write)
//   last_grant   in  requester served most recently
//   grant        out winner (only meaningful when some request is high)
// Macro ARB_ROUND_ROBIN_EN: when defined, a conflict goes to the requester
// not served last; otherwise the D-cache always wins a conflict.
module arb_priority_select
    import rv32i_types::*;
(
    input  logic       icache_read,
    input  logic       dcache_req,
    input  arb_grant_t last_grant,
    output arb_grant_t grant
);

`ifdef ARB_ROUND_ROBIN_EN
    always_comb begin
        grant = GRANT_I;
        if (icache_read && dcache_req) begin
            grant = (last_grant == GRANT_I) ? GRANT_D : GRANT_I;
        end else if (dcache_req) begin
            grant = GRANT_D;
        end
    end
`else
    // Fixed priority has no history; the port is kept so both builds share
    // one interface.
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant = GRANT_I;
        if (dcache_req) begin
            grant = GRANT_D;
        end
    end
`endif

endmodule

// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one physical-memory line port between the
// I-cache (read-only) and the D-cache (read/write). One requester owns the
// port from grant until pmem_resp; address, write data and operation are
// latched at grant so requester inputs may change afterwards.
// Ports:
//   clk, rst                         clock, synchronous active-high reset
//   icache_read/address              I-cache request
//   icache_rdata/resp                I-cache response
//   dcache_read/write/address/wdata  D-cache request
//   dcache_rdata/resp                D-cache response
//   pmem_read/write/address/wdata    memory request (registered)
//   pmem_rdata/resp                  memory response
// Macro ARB_ROUND_ROBIN_EN selects round-robin conflict resolution with a
// last_grant flop; undefined gives fixed D-over-I priority.
module cache_mem_arbiter
    import rv32i_types::*;
#(
    parameter int ADDR_W = 32,
    parameter int LINE_W = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              icache_read,
    input  logic [ADDR_W-1:0] icache_address,
    output logic [LINE_W-1:0] icache_rdata,
    output logic              icache_resp,
    input  logic              dcache_read,
    input  logic              dcache_write,
    input  logic [ADDR_W-1:0] dcache_address,
    input  logic [LINE_W-1:0] dcache_wdata,
    output logic [LINE_W-1:0] dcache_rdata,
    output logic              dcache_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_address,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);

    arb_state_t        state_q, state_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [LINE_W-1:0] wdata_q, wdata_d;
    arb_grant_t        last_grant;
    arb_grant_t        win;
    logic              dcache_req;

    assign dcache_req = dcache_read | dcache_write;

`ifdef ARB_ROUND_ROBIN_EN
    arb_grant_t last_grant_q, last_grant_d;
    assign last_grant = last_grant_q;

    always_comb begin
        last_grant_d = last_grant_q;
        if (state_q == IDLE && (dcache_req || icache_read)) begin
            last_grant_d = win;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) last_grant_q <= GRANT_I;
        else     last_grant_q <= last_grant_d;
    end
`else
    assign last_grant = GRANT_I;
`endif

    arb_priority_select u_sel (
        .icache_read (icache_read),
        .dcache_req  (dcache_req),
        .last_grant  (last_grant),
        .grant       (win)
    );

    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        wr_d    = wr_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            IDLE: begin
                if (dcache_req || icache_read) begin
                    if (win == GRANT_D) begin
                        state_d = D_BUSY;
                        // read+write together is resolved as a write
                        wr_d    = dcache_write;
                        rd_d    = ~dcache_write;
                        addr_d  = dcache_address;
                        wdata_d = dcache_wdata;
                    end else begin
                        state_d = I_BUSY;
                        rd_d    = 1'b1;
                        wr_d    = 1'b0;
                        addr_d  = icache_address;
                    end
                end
            end
            I_BUSY, D_BUSY: begin
                if (pmem_resp) begin
                    state_d = DONE;
                    rd_d    = 1'b0;
                    wr_d    = 1'b0;
                end
            end
            // One dead cycle so the requester can drop its request after resp.
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    assign pmem_read    = rd_q;
    assign pmem_write   = wr_q;
    assign pmem_address = addr_q;
    assign pmem_wdata   = wdata_q;

    // Stray responses in IDLE/DONE never reach a cache.
    assign icache_resp  = pmem_resp & (state_q == I_BUSY);
    assign dcache_resp  = pmem_resp & (state_q == D_BUSY);
    assign icache_rdata = pmem_rdata;
    assign dcache_rdata = pmem_rdata;

endmodule

// File: tb/tb_cache_mem_arbiter.sv
module tb_cache_mem_arbiter;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    logic              clk = 1'b0;
    logic              rst;
    logic              icache_read;
    logic [ADDR_W-1:0] icache_address;
    logic [LINE_W-1:0] icache_rdata;
    logic              icache_resp;
    logic              dcache_read;
    logic              dcache_write;
    logic [ADDR_W-1:0] dcache_address;
    logic [LINE_W-1:0] dcache_wdata;
    logic [LINE_W-1:0] dcache_rdata;
    logic              dcache_resp;
    logic              pmem_read;
    logic              pmem_write;
    logic [ADDR_W-1:0] pmem_address;
    logic [LINE_W-1:0] pmem_wdata;
    logic [LINE_W-1:0] pmem_rdata;
    logic              pmem_resp;

    cache_mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
        .clk            (clk),
        .rst            (rst),
        .icache_read    (icache_read),
        .icache_address (icache_address),
        .icache_rdata   (icache_rdata),
        .icache_resp    (icache_resp),
        .dcache_read    (dcache_read),
        .dcache_write   (dcache_write),
        .dcache_address (dcache_address),
        .dcache_wdata   (dcache_wdata),
        .dcache_rdata   (dcache_rdata),
        .dcache_resp    (dcache_resp),
        .pmem_read      (pmem_read),
        .pmem_write     (pmem_write),
        .pmem_address   (pmem_address),
        .pmem_wdata     (pmem_wdata),
        .pmem_rdata     (pmem_rdata),
        .pmem_resp      (pmem_resp)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic              rd;
        logic              wr;
        logic [ADDR_W-1:0] addr;
        logic [LINE_W-1:0] wdata;
    } req_t;

    typedef struct {
        logic              d;
        logic [LINE_W-1:0] data;
    } resp_t;

    req_t  req_q[$];
    resp_t resp_q[$];
    int    checks   = 0;
    int    failures = 0;

    task automatic chk(input string nm, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic push_req(input logic rd, input logic wr, input logic [ADDR_W-1:0] a, input logic [LINE_W-1:0] wd);
        req_t r;
        r.rd = rd; r.wr = wr; r.addr = a; r.wdata = wd;
        req_q.push_back(r);
    endtask

    task automatic push_resp(input logic d, input logic [LINE_W-1:0] data);
        resp_t r;
        r.d = d; r.data = data;
        resp_q.push_back(r);
    endtask

    // Memory model driven by the stimulus: waits for a strobe, holds it for
    // lat cycles (resp in the last one), then checks the strobe drops.
    // Returns at mid-cycle of the DONE cycle. waited counts low-strobe
    // negedges before the first high one.
    task automatic mem_serve(input int lat, input logic [LINE_W-1:0] data, input bit stray_done, output int waited);
        bit found;
        found  = 0;
        waited = 0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            if ((pmem_read | pmem_write) === 1'b1) found = 1;
            else waited++;
        end
        if (!found) begin
            chk("strobe_timeout", pmem_read | pmem_write, 1'b1);
            return;
        end
        for (int k = 1; k <= lat - 2; k++) begin
            @(negedge clk);
            chk("strobe_held", pmem_read | pmem_write, 1'b1);
        end
        @(posedge clk); #1;
        pmem_resp  = 1'b1;
        pmem_rdata = data;
        @(negedge clk);
        chk("strobe_in_resp_cycle", pmem_read | pmem_write, 1'b1);
        @(posedge clk); #1;
        if (!stray_done) pmem_resp = 1'b0;
        pmem_rdata = '0;
        @(negedge clk);
        chk("strobe_dropped_after_resp", pmem_read | pmem_write, 1'b0);
        if (stray_done) begin
            chk("stray_done_icache_resp", icache_resp, 1'b0);
            chk("stray_done_dcache_resp", dcache_resp, 1'b0);
        end
    endtask

    // Monitor: pops expected responses and memory requests as the DUT
    // presents them.
    initial begin : monitor
        req_t  cur;
        resp_t r;
        bit    prev;
        prev = 0;
        cur.rd = 0; cur.wr = 0; cur.addr = '0; cur.wdata = '0;
        forever begin
            @(negedge clk);
            if (icache_resp === 1'b1 || dcache_resp === 1'b1) begin
                if (resp_q.size() == 0) begin
                    chk("resp_when_none_expected", {icache_resp, dcache_resp}, 2'b00);
                end else begin
                    r = resp_q.pop_front();
                    chk("resp_owner", {icache_resp, dcache_resp}, r.d ? 2'b01 : 2'b10);
                    if (r.d) chk("dcache_rdata", dcache_rdata, r.data);
                    else     chk("icache_rdata", icache_rdata, r.data);
                end
            end
            if ((pmem_read | pmem_write) === 1'b1) begin
                if (!prev) begin
                    if (req_q.size() == 0) begin
                        chk("strobe_when_none_expected", {pmem_read, pmem_write}, 2'b00);
                    end else begin
                        cur = req_q.pop_front();
                        chk("pmem_read", pmem_read, cur.rd);
                        chk("pmem_write", pmem_write, cur.wr);
                        if (cur.wr) chk("pmem_wdata", pmem_wdata, cur.wdata);
                    end
                end
                chk("pmem_address", pmem_address, cur.addr);
                prev = 1;
            end else begin
                prev = 0;
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int w;
        logic [LINE_W-1:0] dA, dD, dI, dW, dW2;
        dA  = {8{32'hAAAA_AAAA}};
        dD  = {8{32'hD00D_0001}};
        dI  = {8{32'h1111_2222}};
        dW  = {16{16'h1234}};
        dW2 = {8{32'hCAFE_F00D}};

        rst = 1'b1;
        icache_read = 0; icache_address = '0;
        dcache_read = 0; dcache_write = 0; dcache_address = '0; dcache_wdata = '0;
        pmem_rdata = '0; pmem_resp = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_pmem_read", pmem_read, 1'b0);
        chk("reset_pmem_write", pmem_write, 1'b0);
        chk("reset_pmem_address", pmem_address, '0);
        chk("reset_pmem_wdata", pmem_wdata, '0);
        chk("reset_icache_resp", icache_resp, 1'b0);
        chk("reset_dcache_resp", dcache_resp, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;

        // 1: lone I-cache read, 5-cycle memory
        icache_read = 1; icache_address = 32'h0000_1000;
        push_req(1, 0, 32'h0000_1000, '0);
        push_resp(0, dA);
        mem_serve(5, dA, 0, w);
        chk("t1_grant_latency", w, 1);
        icache_read = 0;
        @(posedge clk); #1;

        // 2: simultaneous I and D reads, D first, I after 2-cycle gap
        icache_read = 1; icache_address = 32'h0000_3000;
        dcache_read = 1; dcache_address = 32'h0000_4000;
        push_req(1, 0, 32'h0000_4000, '0); push_resp(1, dD);
        push_req(1, 0, 32'h0000_3000, '0); push_resp(0, dI);
        mem_serve(3, dD, 0, w);
        chk("t2_first_latency", w, 1);
        dcache_read = 0;
        mem_serve(2, dI, 0, w);
        chk("t2_turnaround", w, 1);
        icache_read = 0;
        @(posedge clk); #1;

        // 3: D-cache write-back
        dcache_write = 1; dcache_address = 32'h0000_2040; dcache_wdata = dW;
        push_req(0, 1, 32'h0000_2040, dW); push_resp(1, '0);
        mem_serve(4, '0, 0, w);
        chk("t3_latency", w, 1);
        dcache_write = 0;
        @(posedge clk); #1;

        // 2b: second conflict, D was served last
        icache_read = 1; icache_address = 32'h0000_5000;
        dcache_read = 1; dcache_address = 32'h0000_6000;
`ifdef ARB_ROUND_ROBIN_EN
        push_req(1, 0, 32'h0000_5000, '0); push_resp(0, dI);
        push_req(1, 0, 32'h0000_6000, '0); push_resp(1, dD);
        mem_serve(2, dI, 0, w);
        icache_read = 0;
        mem_serve(2, dD, 0, w);
        chk("t2b_turnaround", w, 1);
        dcache_read = 0;
`else
        push_req(1, 0, 32'h0000_6000, '0); push_resp(1, dD);
        push_req(1, 0, 32'h0000_5000, '0); push_resp(0, dI);
        mem_serve(2, dD, 0, w);
        dcache_read = 0;
        mem_serve(2, dI, 0, w);
        chk("t2b_turnaround", w, 1);
        icache_read = 0;
`endif
        @(posedge clk); #1;

        // illegal read+write together -> write
        dcache_read = 1; dcache_write = 1; dcache_address = 32'h0000_7000; dcache_wdata = dW2;
        push_req(0, 1, 32'h0000_7000, dW2); push_resp(1, '0);
        mem_serve(2, '0, 0, w);
        dcache_read = 0; dcache_write = 0;
        @(posedge clk); #1;

        // 4: address change after grant must not reach memory
        icache_read = 1; icache_address = 32'h0000_0100;
        push_req(1, 0, 32'h0000_0100, '0); push_resp(0, dA);
        fork
            mem_serve(3, dA, 0, w);
            begin
                @(posedge clk); #1;
                icache_address = 32'h0000_0200;
            end
        join
        icache_read = 0;
        @(posedge clk); #1;

        // 6: stray resp in IDLE, then stray resp in DONE
        pmem_resp = 1; pmem_rdata = dI;
        @(negedge clk);
        chk("stray_idle_icache_resp", icache_resp, 1'b0);
        chk("stray_idle_dcache_resp", dcache_resp, 1'b0);
        chk("stray_idle_no_strobe", pmem_read | pmem_write, 1'b0);
        @(posedge clk); #1;
        pmem_resp = 0; pmem_rdata = '0;
        dcache_read = 1; dcache_address = 32'h0000_8000;
        push_req(1, 0, 32'h0000_8000, '0); push_resp(1, dD);
        mem_serve(2, dD, 1, w);
        chk("t6_idle_after_stray", w, 1);
        dcache_read = 0;
        @(posedge clk); #1;
        pmem_resp = 0;
        icache_read = 1; icache_address = 32'h0000_9000;
        push_req(1, 0, 32'h0000_9000, '0); push_resp(0, dI);
        mem_serve(2, dI, 0, w);
        chk("t6_idle_after_stray_done", w, 1);
        icache_read = 0;
        @(posedge clk); #1;

        // 5: reset during D_BUSY, memory answers the cycle after
        dcache_read = 1; dcache_address = 32'h0000_A000;
        push_req(1, 0, 32'h0000_A000, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0; dcache_read = 0;
        pmem_resp = 1; pmem_rdata = dD;
        @(negedge clk);
        chk("t5_pmem_read", pmem_read, 1'b0);
        chk("t5_pmem_write", pmem_write, 1'b0);
        chk("t5_dcache_resp", dcache_resp, 1'b0);
        chk("t5_pmem_address", pmem_address, '0);
        chk("t5_pmem_wdata", pmem_wdata, '0);
        @(posedge clk); #1;
        pmem_resp = 0; pmem_rdata = '0;
        icache_read = 1; icache_address = 32'h0000_B000;
        push_req(1, 0, 32'h0000_B000, '0); push_resp(0, dA);
        mem_serve(2, dA, 0, w);
        chk("t5_idle_after_reset", w, 1);
        icache_read = 0;

        repeat (3) @(negedge clk);
        chk("req_queue_drained", req_q.size(), 0);
        chk("resp_queue_drained", resp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
